// File: rtl/ann_layer_mac.sv
// ann_layer_mac: time-multiplexed fully-connected ANN layer with one MAC, writable weight RAM and ReLU/hard-sigmoid activation
module ann_layer_mac #(
  parameter int N_IN = 30,
  parameter int N_OUT = 5,
  parameter int DW = 10,
  parameter int WW = 10,
  parameter int FRAC = 8,
  localparam int NW = N_IN * N_OUT,
  localparam int AW = NW > 1 ? $clog2(NW) : 1
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  act_mode,
  input  logic [N_IN*DW-1:0]    in,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WW-1:0]         wr_data,
  output logic [N_OUT*DW-1:0]   out,
  output logic                  busy,
  output logic                  done
);
  localparam int ACW = DW + WW + $clog2(N_IN) + 1;
  localparam int PW = DW + WW + 1;
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int NB = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam logic signed [ACW-1:0] MAXV = {{(ACW-DW){1'b0}}, {DW{1'b1}}};
  localparam logic signed [ACW-1:0] HALF = ACW'(2 ** (DW - 1));
  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
  state_t state;
  logic [WW-1:0] w_ram [NW];
  logic [N_IN*DW-1:0] in_lat;
  logic mode;
  logic signed [ACW-1:0] acc, x, y;
  logic signed [PW-1:0] prod;
  logic [IW-1:0] i;
  logic [NB-1:0] n;
  logic [AW-1:0] ra;
  logic [DW-1:0] res;
  always_comb begin
    ra = AW'(32'(n) * N_IN + 32'(i));
    prod = PW'($signed({1'b0, in_lat[32'(i)*DW +: DW]})) * PW'($signed(w_ram[ra]));
    x = acc >>> FRAC;
    y = mode ? (x >>> 2) + HALF : x;
    res = y[ACW-1] ? '0 : (y > MAXV) ? '1 : y[DW-1:0];
  end
  always_ff @(posedge Clock)
    if (wr_en && (state == IDLE || state == DONE) && 32'(wr_addr) < NW) w_ram[wr_addr] <= wr_data;
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state <= IDLE;
      out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      acc <= '0;
      i <= '0;
      n <= '0;
      in_lat <= '0;
      mode <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= Start;
          state <= Start ? MAC : IDLE;
          if (Start) begin
            in_lat <= in;
            mode <= act_mode;
            acc <= '0;
            i <= '0;
            n <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACW'(prod);
          if (i == IW'(N_IN - 1)) state <= WB;
          else i <= i + 1'b1;
        end
        WB: begin
          out[32'(n)*DW +: DW] <= res;
          acc <= '0;
          i <= '0;
          if (n == NB'(N_OUT - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            n <= n + 1'b1;
            state <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ann_layer_mac.md
Name: ann_layer_mac

Overview:
- Parametrised, time-multiplexed fully-connected ANN layer for the drowsiness-detector datapath. It generalises the fixed 30-input / 5-hidden / 3-output neuron arrays.
- One multiply-accumulate (MAC) unit iterates over N_OUT neurons × N_IN inputs, using weights from an internal writable weight RAM.
- Applies a run-time selectable activation (ReLU or hard-sigmoid) and presents all neuron outputs in parallel with a start/done handshake.
- Instances are chained to build hidden and output layers.

Parameters:
N_IN, 30, inputs per neuron (≥1)
N_OUT, 5, neurons in the layer (≥1)
DW, 10, unsigned input/output data width
WW, 10, signed two's-complement weight width
FRAC, 8, fractional bits of weight (256 = 1.0 at default)

Ports:
Clock  in  1  sole clock, rising edge
Rst  in  1  synchronous reset, active-low
Start  in  1  one-cycle request to evaluate layer
act_mode  in  1  0 = ReLU, 1 = hard-sigmoid; sampled with Start
in  in  N_IN*DW  flattened inputs, in[i] = bits [i*DW +: DW]
wr_en  in  1  weight write strobe
wr_addr  in  clog2(N_IN*N_OUT)  weight address = neuron*N_IN + input
wr_data  in  WW  signed weight value
out  out  N_OUT*DW  flattened neuron outputs, same packing as in
busy  out  1  high from Start acceptance until DONE
done  out  1  one-cycle pulse, results valid

Behaviour:
- Reset (Rst=0 at a rising edge):
  - FSM→IDLE; out, busy, done, counters and accumulator → 0.
  - Weight RAM is NOT cleared and retains its contents.
- FSM states: IDLE, MAC, WB, DONE.
- IDLE:
  - Start=1 → latch in[] and act_mode into internal registers; clear accumulator, n=0, i=0; go to MAC.
  - busy=1 from the next cycle.
- MAC:
  - acc += in_lat[i] (zero-extended) × W[n*N_IN+i] (sign-extended). One product per cycle.
  - i = N_IN-1 → WB; otherwise i++.
- WB (one cycle):
  - x = acc >>> FRAC (arithmetic shift).
  - ReLU: out[n] = clamp(x, 0, 2^DW-1).
  - Sigmoid: out[n] = clamp((x >>> 2) + 2^(DW-1), 0, 2^DW-1).
  - Then acc=0, i=0. If n = N_OUT-1 → DONE; else n++ → MAC.
- DONE (one cycle): done=1, busy=0 → IDLE. A Start in the DONE cycle is accepted exactly as in IDLE, allowing back-to-back operation.
- Latency: Start accepted at edge T → done high during cycle T + N_OUT*(N_IN+1) + 1. Default: 156 cycles.
- Accumulator width: DW + WW + clog2(N_IN) + 1, signed. It must never overflow for any in/W combination.
- out[n] for neurons not yet written back holds the previous run's value. Each out[n] updates only in its own WB cycle.
- Start while busy: ignored, no restart.
- wr_en while busy: ignored, RAM unchanged. In IDLE/DONE, W[wr_addr] ← wr_data at the edge.
- wr_addr ≥ N_IN*N_OUT: write ignored.
- Changes on in / act_mode after Start acceptance do not affect the current run.
- Rst asserted mid-run: the next edge aborts to IDLE with all outputs 0. A subsequent Start recomputes from the retained weights.

Test Plan:
1. Defaults. For each neuron k, W[k*30+0]=256, all other weights 0, in[0]=123, others 200, act_mode=0, pulse Start → done exactly 156 cycles after Start; every out[k]=123; busy high for 155 cycles.
2. Negative weight. W[0]=10'h300 (−256), other neuron-0 weights 0, in[0]=200 → out[0]=0 with act_mode=0; rerun with act_mode=1 → out[0]=462.
3. Saturation. All 150 weights=256, all in=200 (acc>>>8 = 6000) → every out=1023 in both modes. All weights=10'h300 → ReLU 0, sigmoid 0.
4. Handshake. Pulse Start at cycle 20 of a run and wr_en to address 0 with value 5 at cycle 30 → run completes unchanged at cycle 156; a readback run shows W[0] unchanged. Start asserted during done → second done exactly 156 cycles later.
5. Reset mid-run. Rst=0 for one cycle at cycle 40 → next cycle busy=0, done=0, all out=0. Restart → results identical to the pre-reset expected values (weights retained).
6. Parametrisation. N_IN=4, N_OUT=3, FRAC=0, weights = 1, 2, 3 per neuron, in = {1, 2, 3, 4} → out = {10, 20, 30}, done at cycle 16.
